// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD counter run/pause/clear controller.
package bcd_ctrl_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [1:0] bcd_value_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } ctrl_state_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Clamp each digit to 9 so an out-of-range target is still reachable.
    function automatic bcd_value_t sat_bcd(input bcd_value_t v);
        bcd_value_t r;
        for (int i = 0; i < 2; i++) begin
            r[i] = (v[i] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Prescaler producing a registered one-cycle tick every TICK_DIV enabled cycles.
// en_i low holds the count; clr_i zeroes the count and kills any pending tick.
module bcd_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    // Next count and tick: tick is issued for the cycle after the last count value.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            tick_d = (cnt_q == CntMax);
            cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear controller for the two-digit BCD counter: prescaled count
// enable, clear-by-load, and stop on reaching a latched target.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned BCD_DIGITS = 2
) (
    input  logic            CLOCK_I,
    input  logic            RESETN_I,
    input  logic            START_I,
    input  logic            STOP_I,
    input  logic            CLEAR_I,
    input  logic [1:0][3:0] TARGET_I,
    input  logic [1:0][3:0] BCD_COUNT_I,
    output logic            ENABLE_O,
    output logic            LOAD_O,
    output logic [1:0][3:0] LOAD_VALUE_O,
    output logic [1:0]      STATE_O,
    output logic            DONE_O
);

    if (BCD_DIGITS != 2) begin : g_digits_check
        $error("bcd_count_ctrl supports exactly two BCD digits");
    end

    ctrl_state_t state_q, state_d;
    bcd_value_t  target_q, target_d;
    logic        load_q, load_d;
    logic        done_q, done_d;
    logic        tick_en, tick_clr;
    logic        at_target;

    assign at_target = (BCD_COUNT_I == target_q);

    // State and target registers.
    always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            state_q  <= S_IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next state; CLEAR beats everything, and in RUN the terminal match beats STOP.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (CLEAR_I) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START_I) begin
                        state_d  = S_RUN;
                        target_d = sat_bcd(TARGET_I);
                    end
                end
                S_RUN: begin
                    if (at_target) begin
                        state_d = S_DONE;
                    end else if (STOP_I) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (START_I) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode: prescaler runs only in RUN cycles that stay in RUN.
    always_comb begin
        tick_en  = (state_q == S_RUN) && !CLEAR_I && !at_target && !STOP_I;
        tick_clr = CLEAR_I || ((state_q == S_IDLE) && START_I);
        load_d   = CLEAR_I;
        done_d   = (state_d == S_DONE);
    end

    // Registered load and done outputs.
    always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            load_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            load_q <= load_d;
            done_q <= done_d;
        end
    end

    bcd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (CLOCK_I),
        .rst_ni (RESETN_I),
        .en_i   (tick_en),
        .clr_i  (tick_clr),
        .tick_o (ENABLE_O)
    );

    assign LOAD_O       = load_q;
    assign LOAD_VALUE_O = '0;
    assign STATE_O      = state_q;
    assign DONE_O       = done_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with a behavioural BCD counter in the loop.
module tb_bcd_count_ctrl;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, stop, clear;
    logic [7:0]      target;
    logic [7:0]      bcd_in;
    logic            enable, load, done;
    logic [1:0][3:0] load_value;
    logic [1:0]      state;

    logic            model_en;
    logic [7:0]      bcd_model, bcd_force;

    int n_total = 0;
    int n_bad   = 0;
    int errs, ticks, c5, cd;

    assign bcd_in = model_en ? bcd_model : bcd_force;

    always #5 clk = ~clk;

    bcd_count_ctrl #(
        .TICK_DIV   (4),
        .BCD_DIGITS (2)
    ) dut (
        .CLOCK_I      (clk),
        .RESETN_I     (rst_n),
        .START_I      (start),
        .STOP_I       (stop),
        .CLEAR_I      (clear),
        .TARGET_I     (target),
        .BCD_COUNT_I  (bcd_in),
        .ENABLE_O     (enable),
        .LOAD_O       (load),
        .LOAD_VALUE_O (load_value),
        .STATE_O      (state),
        .DONE_O       (done)
    );

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {((v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1), 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Counter being controlled: load has priority over count enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      bcd_model <= 8'h00;
        else if (load)   bcd_model <= load_value;
        else if (enable) bcd_model <= bcd_inc(bcd_model);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; pulse is sampled by the next rising edge.
    task automatic pulse(input logic s, input logic p, input logic c);
        start = s; stop = p; clear = c;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        c5 = -1; cd = -1; ticks = 0;
        for (int k = 1; k <= limit && cd < 0; k++) begin
            @(negedge clk);
            if (enable) ticks++;
            if (bcd_in == 8'h05 && c5 < 0) c5 = k;
            if (done && cd < 0) cd = k;
        end
        check_eq("done_within_bound", cd > 0, 1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        target = 8'h00; model_en = 1'b1; bcd_force = 8'h00;

        // 1. reset then idle
        #9;
        check_eq("rst_state", state, 2'b00);
        check_eq("rst_enable", enable, 0);
        check_eq("rst_load", load, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_load_value", load_value, 8'h00);
        #1 rst_n = 1'b1;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (enable || load || done || state != 2'b00) errs++;
        end
        check_eq("idle_quiet", errs, 0);

        // 2. tick cadence with target 99
        target = 8'h99;
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("run_enter", state, 2'b01);
        check_eq("run_no_tick_yet", enable, 0);
        errs = 0; ticks = 0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (enable) ticks++;
            if (enable != (k % 4 == 0)) errs++;
        end
        check_eq("cadence_pattern", errs, 0);
        check_eq("cadence_ticks", ticks, 10);
        check_eq("count_after_40", bcd_in, 8'h10);

        // 3. pause one cycle before a tick, then resume
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("pause_state", state, 2'b10);
        check_eq("pause_tick_dropped", enable, 0);
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (enable || state != 2'b10) errs++;
        end
        check_eq("pause_hold", errs, 0);
        check_eq("pause_count", bcd_in, 8'h10);
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("resume_state", state, 2'b01);
        check_eq("resume_no_tick_yet", enable, 0);
        @(negedge clk);
        check_eq("resume_tick", enable, 1);
        @(negedge clk);
        check_eq("resume_tick_single", enable, 0);

        // clear mid-run
        pulse(1'b0, 1'b0, 1'b1);
        check_eq("clear_load", load, 1);
        check_eq("clear_load_value", load_value, 8'h00);
        check_eq("clear_state", state, 2'b00);
        check_eq("clear_enable", enable, 0);
        @(negedge clk);
        check_eq("clear_load_single", load, 0);
        check_eq("counter_cleared", bcd_in, 8'h00);

        // 4. terminal at 05
        target = 8'h05;
        pulse(1'b1, 1'b0, 1'b0);
        wait_done(100);
        check_eq("done_one_after_match", cd - c5, 1);
        check_eq("term_ticks", ticks, 5);
        check_eq("term_state", state, 2'b11);
        check_eq("term_count", bcd_in, 8'h05);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            start = (k == 3); stop = (k == 8);
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            if (enable || !done || state != 2'b11) errs++;
        end
        check_eq("done_sticky", errs, 0);
        check_eq("done_count_frozen", bcd_in, 8'h05);

        // 5. clear beats start from DONE; target 0F saturates to 09
        target = 8'h0F;
        pulse(1'b1, 1'b0, 1'b1);
        check_eq("prio_load", load, 1);
        check_eq("prio_load_value", load_value, 8'h00);
        check_eq("prio_state", state, 2'b00);
        check_eq("prio_done", done, 0);
        check_eq("prio_enable", enable, 0);
        @(negedge clk);
        check_eq("prio_start_dropped", state, 2'b00);
        check_eq("prio_load_single", load, 0);
        pulse(1'b1, 1'b0, 1'b0);
        target = 8'h02;
        wait_done(100);
        check_eq("sat_ticks", ticks, 9);
        check_eq("sat_count", bcd_in, 8'h09);

        // 6. mid-run reset, then zero target
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        target = 8'h99;
        pulse(1'b1, 1'b0, 1'b0);
        errs = 0;
        for (int k = 0; k < 10 && !enable; k++) @(negedge clk);
        check_eq("tick_before_reset", enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_enable", enable, 0);
        check_eq("async_rst_state", state, 2'b00);
        check_eq("async_rst_load", load, 0);
        check_eq("async_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (load || state != 2'b00) errs++;
        end
        check_eq("no_load_after_rst", errs, 0);
        target = 8'h00;
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("zero_run", state, 2'b01);
        check_eq("zero_run_enable", enable, 0);
        @(negedge clk);
        check_eq("zero_done_state", state, 2'b11);
        check_eq("zero_done", done, 1);
        check_eq("zero_enable", enable, 0);

        // terminal wins over STOP and suppresses a due tick
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        model_en = 1'b0; bcd_force = 8'h00; target = 8'h03;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("pre_term_state", state, 2'b01);
        stop = 1'b1; bcd_force = 8'h03;
        @(negedge clk);
        stop = 1'b0;
        check_eq("term_over_stop", state, 2'b11);
        check_eq("term_tick_suppressed", enable, 0);
        check_eq("term_over_stop_done", done, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
- Run/pause/clear controller for the two-digit BCD counter, with a count-enable input added on the counter side.
- Generates a prescaled one-cycle count-enable tick and issues load pulses to clear the counter.
- Watches the counter's BCD output and stops the count when a latched target is reached.
- Sits between board push-button pulse logic and the BCD counter datapath.

Parameters:
- TICK_DIV, 4, clock cycles per count-enable tick; legal range 2..2^16.
- BCD_DIGITS, 2, number of BCD digits handled; fixed at 2 for this release.

Ports:
- CLOCK_I  in  1  system clock; all logic is rising-edge.
- RESETN_I  in  1  reset, asynchronous, active-low.
- START_I  in  1  one-cycle pulse: start or resume counting.
- STOP_I  in  1  one-cycle pulse: pause counting.
- CLEAR_I  in  1  one-cycle pulse: clear the counter to 00 and return to idle.
- TARGET_I  in  [1:0][3:0]  terminal BCD value; [1] is the tens digit.
- BCD_COUNT_I  in  [1:0][3:0]  current counter value, fed back from the counter.
- ENABLE_O  out  1  one-cycle count-enable tick to the counter.
- LOAD_O  out  1  one-cycle load pulse to the counter.
- LOAD_VALUE_O  out  [1:0][3:0]  load value to the counter; always 00 in this release.
- STATE_O  out  2  current state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- DONE_O  out  1  high while in DONE.

Behaviour:
- Reset: state IDLE, prescaler 0, latched target 00. ENABLE_O, LOAD_O and DONE_O are 0; LOAD_VALUE_O is 00; STATE_O is 00.
- All outputs are registered. Inputs are sampled on each rising edge.
- Priority for simultaneous pulses: CLEAR > START > STOP.
- CLEAR, in any state:
  - Next cycle: state IDLE, prescaler 0, LOAD_O=1 for exactly one cycle, LOAD_VALUE_O=00, ENABLE_O=0.
- IDLE:
  - START: latch TARGET_I, clearing any digit >9 to 9. Go to RUN with prescaler 0.
  - STOP: ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - ENABLE_O=1 in the cycle after the prescaler is sampled at TICK_DIV-1; first tick TICK_DIV cycles after entering RUN.
  - STOP: go to PAUSE; prescaler holds its value; no tick is issued that cycle.
  - START: ignored.
- Terminal detect (RUN only):
  - Applies when BCD_COUNT_I equals the latched target. Go to DONE the next cycle and suppress any tick scheduled for that cycle.
  - The check is made every cycle, including the cycle in which STOP arrives; terminal detect takes precedence over STOP.
- PAUSE:
  - START: resume RUN from the held prescaler value.
  - STOP: ignored.
- DONE:
  - DONE_O=1. ENABLE_O is held at 0. START and STOP are ignored. Only CLEAR (or reset) leaves DONE.
- Latched target is held for the whole run; TARGET_I changes after START have no effect until the next START from IDLE.
- Target 00 with counter at 00: START leads to RUN for one cycle, then DONE, with no ENABLE_O.
- Counter wrap past 99 cannot occur while the target is ≤99: the target is always reached first.
- BCD_COUNT_I is trusted to be valid BCD; no checking is done.
- Invariant: ENABLE_O and LOAD_O are never high in the same cycle.
- Reset asserted mid-run: all state returns immediately to reset values; no LOAD_O is issued.

Decomposition:
- Package bcd_ctrl_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - typedef bcd_value_t ([1:0] bcd_digit_t).
  - enum ctrl_state_t {S_IDLE=2'b00, S_RUN=2'b01, S_PAUSE=2'b10, S_DONE=2'b11}.
  - constant BCD_MAX_DIGIT=4'd9.
- Sub-module bcd_tick_gen: parameterised prescaler with enable (hold) and sync clear, producing a registered one-cycle tick.
- The FSM, target latch and compare stay in bcd_count_ctrl.

Test Plan (TICK_DIV=4 throughout):
1. Reset then idle: RESETN_I low 10 ns, then high; no pulses for 100 ns -> STATE_O=00; ENABLE_O, LOAD_O, DONE_O stay 0.
2. Tick cadence: TARGET_I=99, START pulse, counter model counting on ENABLE_O -> ENABLE_O high every 4th cycle. After 40 cycles BCD_COUNT_I=10.
3. Pause/resume: STOP one cycle before a tick -> STATE_O=10, no tick for 20 cycles. START -> next tick arrives exactly 1 cycle after re-entering RUN, since the prescaler was held at 3.
4. Terminal: TARGET_I=05, START -> DONE_O rises the cycle after BCD_COUNT_I=05. No further ENABLE_O. START and STOP ignored while in DONE.
5. Clear from DONE, and priority: CLEAR and START in the same cycle -> LOAD_O for one cycle with LOAD_VALUE_O=00, STATE_O=00; START is dropped. Also TARGET_I=0F latched as 09.
6. Mid-run reset and zero target:
   - RESETN_I low during RUN -> all outputs 0 asynchronously.
   - TARGET_I=00 with count 00, then START -> DONE after 1 RUN cycle with zero ticks.
